// File: rtl/cpu_bus_bridge.sv
// 65C816 Phi2 bus to Wishbone classic master bridge.
// Each valid CPU bus cycle becomes one Wishbone cycle; RDY stretches the CPU for slow slaves.
module cpu_bus_bridge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WR_DELAY    = 3,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        wb_clk_i,
  input  logic        wb_reset_n_i,
  input  logic        ext_phi2_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_data_i,
  input  logic        cpu_rwb_i,
  input  logic        cpu_vda_i,
  input  logic        cpu_vpa_i,
  output logic [7:0]  cpu_data_o,
  output logic        cpu_data_oe_o,
  output logic        cpu_rdy_o,
  output logic        timeout_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [23:0] wb_adr_o,
  output logic [7:0]  wb_dat_o,
  input  logic [7:0]  wb_dat_i,
  input  logic        wb_ack_i
);

  localparam int unsigned WR_CNT_W = 4;
  localparam int unsigned TO_CNT_W = 8;
  localparam logic [WR_CNT_W-1:0] WR_LAST = WR_CNT_W'(WR_DELAY - 1);
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WDLY, S_REQ, S_HOLD} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                  r_hist;
  logic                  w_sync;
  logic                  w_rise;
  logic                  w_fall;
  logic [WR_CNT_W-1:0]   r_wr_cnt;
  logic [TO_CNT_W-1:0]   r_to_cnt;
  logic                  r_stretch;
  logic                  r_cyc;
  logic                  r_we;
  logic [23:0]           r_adr;
  logic [7:0]            r_wdat;
  logic [7:0]            r_rdata;
  logic                  r_oe;
  logic                  r_rdy;
  logic                  r_timeout;
  logic                  w_start;
  logic                  w_wdat_take;
  logic                  w_ack_take;
  logic                  w_timeout;
  logic                  w_hold_exit;
  logic                  w_busy;

  // Phi2 synchroniser plus history flop for edge detection
  always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ext_phi2_i};
      r_hist <= w_sync;
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = w_sync & ~r_hist;
  assign w_fall = ~w_sync & r_hist;
  assign w_busy = (r_state == S_WDLY) || (r_state == S_REQ);

  always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) r_state <= S_IDLE;
    else               r_state <= w_state_nxt;
  end

  // A stretched read stays in HOLD through the next Phi2-high phase to drive data
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_wdat_take = 1'b0;
    w_ack_take  = 1'b0;
    w_timeout   = 1'b0;
    w_hold_exit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise && (cpu_vda_i || cpu_vpa_i)) begin
          w_start     = 1'b1;
          w_state_nxt = cpu_rwb_i ? S_REQ : S_WDLY;
        end
      end
      S_WDLY: begin
        if (r_wr_cnt == WR_LAST) begin
          w_wdat_take = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (wb_ack_i) begin
          w_ack_take  = 1'b1;
          w_state_nxt = S_HOLD;
        end else if (r_to_cnt == TO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_fall || (!w_sync && !(r_stretch && !r_we))) begin
          w_hold_exit = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      r_wr_cnt  <= '0;
      r_to_cnt  <= '0;
      r_stretch <= 1'b0;
      r_cyc     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_wdat    <= '0;
      r_rdata   <= '0;
      r_oe      <= 1'b0;
      r_rdy     <= 1'b1;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout;
      r_cyc     <= (w_state_nxt == S_REQ);
      r_wr_cnt  <= (r_state == S_WDLY) ? r_wr_cnt + WR_CNT_W'(1) : '0;
      r_to_cnt  <= (r_state == S_REQ)  ? r_to_cnt + TO_CNT_W'(1) : '0;
      if (w_start) begin
        r_adr <= {cpu_data_i, cpu_addr_i};
        r_we  <= ~cpu_rwb_i;
      end
      if (w_wdat_take) r_wdat <= cpu_data_i;
      if (w_ack_take && !r_we)     r_rdata <= wb_dat_i;
      else if (w_timeout && !r_we) r_rdata <= 8'hFF;
      if (w_ack_take || w_timeout || w_hold_exit) r_rdy <= 1'b1;
      else if (w_fall && w_busy)                  r_rdy <= 1'b0;
      if (r_state == S_IDLE)     r_stretch <= 1'b0;
      else if (w_fall && w_busy) r_stretch <= 1'b1;
      r_oe <= (w_state_nxt == S_HOLD) && !r_we && w_sync;
    end
  end

  assign cpu_data_o    = r_rdata;
  assign cpu_data_oe_o = r_oe;
  assign cpu_rdy_o     = r_rdy;
  assign timeout_o     = r_timeout;
  assign wb_cyc_o      = r_cyc;
  assign wb_stb_o      = r_cyc;
  assign wb_we_o       = r_we;
  assign wb_adr_o      = r_adr;
  assign wb_dat_o      = r_wdat;

endmodule
